// File: rtl/ifmap_feeder_pkg.sv
// Shared definitions for the input-feature-map feeder and the PE array.
package ifmap_feeder_pkg;

  localparam int unsigned TOP_BITS   = 2;
  localparam int unsigned BOT_BITS   = 14;
  localparam int unsigned DATA_WIDTH = TOP_BITS + BOT_BITS;

  typedef logic [DATA_WIDTH-1:0] fxp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_EMIT,
    ST_GAP,
    ST_DONE
  } feeder_state_e;

endpackage

// File: rtl/feeder_addr_gen.sv
// Row/column walker for the feeder: buffer address, row parity, last-pixel flag.
module feeder_addr_gen #(
  parameter int unsigned G_BUF_ADDR_WIDTH = 10,
  parameter int unsigned G_IMAGE_HEIGHT   = 28,
  parameter int unsigned G_IMAGE_WIDTH    = 28
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        load_i,
  input  logic                        step_i,
  input  logic [G_BUF_ADDR_WIDTH-1:0] base_addr_i,
  output logic [G_BUF_ADDR_WIDTH-1:0] addr_o,
  output logic                        row_odd_o,
  output logic                        last_o
);

  localparam int unsigned RW = (G_IMAGE_HEIGHT > 1) ? $clog2(G_IMAGE_HEIGHT) : 1;
  localparam int unsigned CW = (G_IMAGE_WIDTH > 1) ? $clog2(G_IMAGE_WIDTH) : 1;

  logic [RW-1:0]               row_q;
  logic [CW-1:0]               col_q;
  logic [G_BUF_ADDR_WIDTH-1:0] addr_q;
  logic                        col_end;
  logic                        row_end;

  assign col_end = (col_q == CW'(G_IMAGE_WIDTH - 1));
  assign row_end = (row_q == RW'(G_IMAGE_HEIGHT - 1));

  // Row-major image is contiguous, so the address simply increments (wrapping).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else if (load_i) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= base_addr_i;
    end else if (step_i) begin
      addr_q <= addr_q + 1'b1;
      if (col_end) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign addr_o    = addr_q;
  assign row_odd_o = row_q[0];
  assign last_o    = col_end && row_end;

endmodule

// File: rtl/ifmap_feeder.sv
// Streams an image from the global buffer to the first PE as Q-format pixels.
module ifmap_feeder
  import ifmap_feeder_pkg::*;
#(
  parameter int unsigned G_BUF_ADDR_WIDTH = 10,
  parameter int unsigned G_BUF_DATA_WIDTH = 8,
  parameter int unsigned G_TOP_BITS       = 2,
  parameter int unsigned G_BOT_BITS       = 14,
  parameter int unsigned G_KERNEL_SIZE    = 5,
  parameter int unsigned G_IMAGE_HEIGHT   = 28,
  parameter int unsigned G_IMAGE_WIDTH    = 28
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               start_i,
  input  logic [G_BUF_ADDR_WIDTH-1:0]        base_addr_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               buf_rd_en_o,
  output logic [G_BUF_ADDR_WIDTH-1:0]        buf_addr_o,
  input  logic [G_BUF_DATA_WIDTH-1:0]        buf_data_i,
  output logic                               ifmap_vld_o,
  output logic                               ifmap_row_o,
  output logic [G_TOP_BITS+G_BOT_BITS-1:0]   ifmap_o,
  output logic                               psum_vld_o,
  output logic [G_TOP_BITS+G_BOT_BITS-1:0]   psum_o
);

  localparam int unsigned OUT_W   = G_TOP_BITS + G_BOT_BITS;
  localparam int unsigned PAD_W   = G_BOT_BITS - G_BUF_DATA_WIDTH;
  localparam int unsigned GAP_CYC = (G_KERNEL_SIZE > 2) ? G_KERNEL_SIZE - 2 : 0;
  localparam int unsigned GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  feeder_state_e               state_q, state_d;
  logic [GW-1:0]               gap_cnt_q;
  logic [G_BUF_DATA_WIDTH-1:0] pix_q;
  logic                        load;
  logic                        step;
  logic                        last_pix;
  logic                        row_odd;
  logic                        emit;

  feeder_addr_gen #(
    .G_BUF_ADDR_WIDTH (G_BUF_ADDR_WIDTH),
    .G_IMAGE_HEIGHT   (G_IMAGE_HEIGHT),
    .G_IMAGE_WIDTH    (G_IMAGE_WIDTH)
  ) u_addr_gen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (load),
    .step_i      (step),
    .base_addr_i (base_addr_i),
    .addr_o      (buf_addr_o),
    .row_odd_o   (row_odd),
    .last_o      (last_pix)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the address walker advances on each entry into READ.
  // The last pixel leaves EMIT straight for DONE so done_o lands the cycle
  // after the final valid.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_READ;
          load    = 1'b1;
        end
      end
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: state_d = ST_EMIT;
      ST_EMIT: begin
        if (last_pix) begin
          state_d = ST_DONE;
        end else if (GAP_CYC == 0) begin
          state_d = ST_READ;
          step    = 1'b1;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYC - 1)) begin
          state_d = ST_READ;
          step    = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Idle-cycle counter, cleared whenever the FSM is outside GAP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gap_cnt_q <= '0;
    end else if (state_q == ST_GAP) begin
      gap_cnt_q <= gap_cnt_q + 1'b1;
    end else begin
      gap_cnt_q <= '0;
    end
  end

  // Capture buffer data, valid the cycle after the read strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pix_q <= '0;
    end else if (state_q == ST_WAIT) begin
      pix_q <= buf_data_i;
    end
  end

  assign emit        = (state_q == ST_EMIT);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign buf_rd_en_o = (state_q == ST_READ);
  assign ifmap_vld_o = emit;
  assign ifmap_row_o = emit & ~row_odd;
  assign ifmap_o     = emit ? (OUT_W'(pix_q) << PAD_W) : '0;
  assign psum_vld_o  = emit;
  assign psum_o      = '0;

endmodule

// File: tb/tb_ifmap_feeder.sv
// Randomized bench for ifmap_feeder against a cycle-position reference model.
module tb_ifmap_feeder;

  localparam int AW       = 10;
  localparam int DW       = 8;
  localparam int K        = 5;
  localparam int H        = 28;
  localparam int W        = 28;
  localparam int NPIX     = H * W;
  localparam int PER      = K + 1;
  localparam int DONE_CYC = 3 + PER * (NPIX - 1) + 1;
  localparam int MEMSZ    = 1 << AW;

  logic          clk_i;
  logic          rst_ni;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic          busy_o;
  logic          done_o;
  logic          buf_rd_en_o;
  logic [AW-1:0] buf_addr_o;
  logic [DW-1:0] buf_data_i;
  logic          ifmap_vld_o;
  logic          ifmap_row_o;
  logic [15:0]   ifmap_o;
  logic          psum_vld_o;
  logic [15:0]   psum_o;

  logic [7:0] mem [0:MEMSZ-1];

  int n_total;
  int n_bad;
  int cyc;

  ifmap_feeder #(
    .G_BUF_ADDR_WIDTH (AW),
    .G_BUF_DATA_WIDTH (DW),
    .G_TOP_BITS       (2),
    .G_BOT_BITS       (14),
    .G_KERNEL_SIZE    (K),
    .G_IMAGE_HEIGHT   (H),
    .G_IMAGE_WIDTH    (W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .buf_rd_en_o (buf_rd_en_o),
    .buf_addr_o  (buf_addr_o),
    .buf_data_i  (buf_data_i),
    .ifmap_vld_o (ifmap_vld_o),
    .ifmap_row_o (ifmap_row_o),
    .ifmap_o     (ifmap_o),
    .psum_vld_o  (psum_vld_o),
    .psum_o      (psum_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Synchronous-read buffer: data appears the cycle after the strobe.
  always @(posedge clk_i) begin
    if (buf_rd_en_o) buf_data_i <= mem[buf_addr_o];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  32'(busy_o),      0);
    check({tag, "_done"},  32'(done_o),      0);
    check({tag, "_rd"},    32'(buf_rd_en_o), 0);
    check({tag, "_addr"},  32'(buf_addr_o),  0);
    check({tag, "_vld"},   32'(ifmap_vld_o), 0);
    check({tag, "_row"},   32'(ifmap_row_o), 0);
    check({tag, "_ifmap"}, 32'(ifmap_o),     0);
    check({tag, "_pvld"},  32'(psum_vld_o),  0);
    check({tag, "_psum"},  32'(psum_o),      0);
  endtask

  // mode 1: fixed-value spot checks; mode 2: wrap + special pixel spot checks.
  task automatic run_image(input int base, input bit mid_start, input int abort_at, input int mode);
    int  last_vld;
    int  n_vld;
    int  n_done;
    int  n_rd;
    int  n_em;
    bit  exp_rd;
    bit  exp_vld;
    bit  aborted;
    logic [31:0] exp_px;
    logic [31:0] exp_addr;
    last_vld = -1;
    n_vld    = 0;
    n_done   = 0;
    aborted  = 1'b0;
    @(negedge clk_i);
    cyc = 0;
    check("idle_busy", 32'(busy_o), 0);
    base_addr_i = AW'(base);
    start_i     = 1'b1;
    for (int c = 1; c <= DONE_CYC + 6; c++) begin
      @(negedge clk_i);
      cyc         = c;
      start_i     = (mid_start && (c == 100 || c == DONE_CYC)) ? 1'b1 : 1'b0;
      base_addr_i = mid_start ? AW'($urandom) : AW'(base);

      exp_rd   = ((c - 1) % PER == 0) && ((c - 1) / PER < NPIX);
      n_rd     = (c - 1) / PER;
      if (n_rd > NPIX - 1) n_rd = NPIX - 1;
      exp_addr = 32'((base + n_rd) % MEMSZ);
      exp_vld  = (c >= 3) && ((c - 3) % PER == 0) && ((c - 3) / PER < NPIX);
      n_em     = (c >= 3) ? (c - 3) / PER : 0;
      exp_px   = exp_vld ? 32'(mem[(base + n_em) % MEMSZ]) * 64 : 0;

      check("busy",  32'(busy_o),      32'(c <= DONE_CYC));
      check("done",  32'(done_o),      32'(c == DONE_CYC));
      check("rd_en", 32'(buf_rd_en_o), 32'(exp_rd));
      check("addr",  32'(buf_addr_o),  exp_addr);
      check("vld",   32'(ifmap_vld_o), 32'(exp_vld));
      check("ifmap", 32'(ifmap_o),     exp_px);
      check("row",   32'(ifmap_row_o), 32'(exp_vld && ((n_em / W) % 2 == 0)));
      check("pvld",  32'(psum_vld_o),  32'(exp_vld));
      check("psum",  32'(psum_o),      0);

      if (mode == 1 && c == 3) begin
        check("px0_const", 32'(ifmap_o), 32'h0040);
        check("px0_row",   32'(ifmap_row_o), 1);
      end
      if (mode == 1 && c == 3 + PER * 28) begin
        check("px28_const", 32'(ifmap_o), 32'h0740);
        check("px28_row",   32'(ifmap_row_o), 0);
      end
      if (mode == 2 && c == 1 + PER * 24) begin
        check("wrap_addr", 32'(buf_addr_o), 0);
        check("wrap_rd",   32'(buf_rd_en_o), 1);
      end
      if (mode == 2 && c == 3 + PER * 5) check("px_ff", 32'(ifmap_o), 32'h3FC0);
      if (mode == 2 && c == 3 + PER * 6) check("px_80", 32'(ifmap_o), 32'h2000);

      if (done_o) n_done++;
      if (ifmap_vld_o) begin
        if (last_vld >= 0) check("spacing", 32'(c - last_vld), 32'(PER));
        last_vld = c;
        n_vld++;
      end

      if (c == abort_at) begin
        rst_ni = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (2) @(negedge clk_i);
        check_zero("rst_hold");
        rst_ni   = 1'b1;
        start_i  = 1'b0;
        aborted  = 1'b1;
        break;
      end
    end
    start_i = 1'b0;
    if (!aborted) begin
      check("vld_count",  32'(n_vld),  32'(NPIX));
      check("done_count", 32'(n_done), 1);
    end
  endtask

  initial begin
    int b;
    n_total     = 0;
    n_bad       = 0;
    cyc         = 0;
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    base_addr_i = '0;
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'((i + 1) % 256);
    repeat (3) @(negedge clk_i);
    check_zero("reset");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check_zero("post_reset");

    run_image(0, 1'b0, 0, 1);

    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
    mem[(1000 + 5) % MEMSZ] = 8'hFF;
    mem[(1000 + 6) % MEMSZ] = 8'h80;
    run_image(1000, 1'b1, 0, 2);

    repeat (3) @(negedge clk_i);
    b = int'($urandom_range(1, MEMSZ - 1));
    run_image(b, 1'b0, 500, 0);

    repeat (3) @(negedge clk_i);
    check_zero("after_abort");
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
    b = int'($urandom_range(0, MEMSZ - 1));
    run_image(b, 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
